// File: rtl/perf_counter_dumper.sv
// Debug-side bus initiator that walks every performance counter, reads it, optionally
// clears it, and streams {index, value} records to a valid/ready consumer.
module perf_counter_dumper #(
  parameter int NUM_COUNTERS   = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clear_after_read,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_index,
  output logic [31:0] out_data
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_IDX     = 4'(NUM_COUNTERS - 1);

  // Address tags of the counter window, in declaration (= dump) order.
  typedef enum logic [7:0] {
    ICACHE_HIT       = 8'd0,
    ICACHE_MISS      = 8'd1,
    DCACHE_HIT       = 8'd2,
    DCACHE_MISS      = 8'd3,
    L2_HIT           = 8'd4,
    L2_MISS          = 8'd5,
    EWB_WRITES       = 8'd6,
    BRANCH_TOTAL     = 8'd7,
    BRANCH_CORRECT   = 8'd8,
    BRANCH_INCORRECT = 8'd9,
    PREFETCH_HIT     = 8'd10,
    PREFETCH_READ    = 8'd11
  } counter_addr_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CLR  = 3'd2,
    EMIT = 3'd3,
    FIN  = 3'd4
  } state_t;

  function automatic counter_addr_t tag_of(input logic [3:0] i);
    case (i)
      4'd0:    tag_of = ICACHE_HIT;
      4'd1:    tag_of = ICACHE_MISS;
      4'd2:    tag_of = DCACHE_HIT;
      4'd3:    tag_of = DCACHE_MISS;
      4'd4:    tag_of = L2_HIT;
      4'd5:    tag_of = L2_MISS;
      4'd6:    tag_of = EWB_WRITES;
      4'd7:    tag_of = BRANCH_TOTAL;
      4'd8:    tag_of = BRANCH_CORRECT;
      4'd9:    tag_of = BRANCH_INCORRECT;
      4'd10:   tag_of = PREFETCH_HIT;
      4'd11:   tag_of = PREFETCH_READ;
      default: tag_of = ICACHE_HIT;
    endcase
  endfunction

  state_t        state, state_next;
  logic [3:0]    idx, idx_next;
  logic [31:0]   data, data_next;
  logic          err_next;
  logic          clear_mode, clear_mode_next;
  logic [TW-1:0] tcnt;
  logic          in_access;
  logic          timeout;
  counter_addr_t tag;

  assign tag       = tag_of(idx);
  assign in_access = (state == RD) || (state == CLR);
  assign timeout   = in_access && !mem_resp && (tcnt == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      data       <= '0;
      err        <= 1'b0;
      clear_mode <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      data       <= data_next;
      err        <= err_next;
      clear_mode <= clear_mode_next;
    end
  end

  // Access timer restarts on every state change, so each RD/CLR gets its own budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state_next != state) begin
      tcnt <= '0;
    end else if (in_access && !mem_resp) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // Stream handshake: a record transfers on a rising edge where out_valid & out_ready;
  // while out_valid is high and out_ready low, out_index/out_data do not change.
  always_comb begin
    state_next      = state;
    idx_next        = idx;
    data_next       = data;
    err_next        = err;
    clear_mode_next = clear_mode;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_addr        = 32'h0;
    out_valid       = 1'b0;
    out_index       = 4'h0;
    out_data        = 32'h0;
    done            = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_next      = RD;
          idx_next        = 4'h0;
          err_next        = 1'b0;
          clear_mode_next = clear_after_read;
        end
      end
      RD: begin
        mem_read = 1'b1;
        mem_addr = {24'h0, tag};
        if (mem_resp) begin
          data_next  = mem_rdata;
          state_next = clear_mode ? CLR : EMIT;
        end else if (timeout) begin
          // An unreadable counter is reported as all-ones and left uncleared.
          data_next  = 32'hFFFF_FFFF;
          err_next   = 1'b1;
          state_next = EMIT;
        end
      end
      CLR: begin
        mem_write = 1'b1;
        mem_addr  = {24'h0, tag};
        if (mem_resp) begin
          state_next = EMIT;
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_index = idx;
        out_data  = data;
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            state_next = FIN;
          end else begin
            idx_next   = idx + 4'd1;
            state_next = RD;
          end
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign mem_wdata = 32'h0;

endmodule

// File: tb/tb_perf_counter_dumper.sv
// Bench for perf_counter_dumper: counter-window responder model, record scoreboard,
// table of dump scenarios and a mid-dump reset sequence.
module tb_perf_counter_dumper;

  localparam int N      = 12;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clear_after_read;
  logic        busy, done, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic        out_valid, out_ready;
  logic [3:0]  out_index;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  perf_counter_dumper #(.NUM_COUNTERS(N), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .start(start), .clear_after_read(clear_after_read),
    .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_data(out_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- responder model: the counter window ----------------
  logic [31:0] mem [N];
  logic [31:0] load_vals [N];
  logic        load_req = 1'b0;
  int          silent_idx = -1;
  int          lat_max = 0;
  int          wait_cnt = 0;
  int          lat_target = 0;
  int          writes = 0;
  logic [7:0]  last_rd_addr = 8'h0;
  logic [7:0]  a;

  assign a         = mem_addr[7:0];
  assign mem_resp  = (mem_read || mem_write) && (int'(a) != silent_idx) &&
                     (lat_max == 0 || wait_cnt >= lat_target);
  assign mem_rdata = (mem_read && int'(a) < N) ? mem[a[3:0]] : 32'h0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) mem[i] <= load_vals[i];
    end
    if (mem_resp) begin
      if (mem_write) begin
        chk("write_follows_read_addr", {56'h0, a}, {56'h0, last_rd_addr});
        chk("write_addr_high_zero", {40'h0, mem_addr[31:8]}, 64'h0);
        if (int'(a) < N) mem[a[3:0]] <= 32'h0;
        writes++;
      end else begin
        last_rd_addr <= a;
      end
      wait_cnt   <= 0;
      lat_target <= (lat_max == 0) ? 0 : $urandom_range(0, lat_max);
    end else if (mem_read || mem_write) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  // ---------------- consumer: out_ready driver ----------------
  bit rnd_ready = 1'b0;
  int hold_idx = -1;
  int hold_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (rnd_ready) begin
      out_ready = 1'($urandom_range(0, 1));
    end else if (hold_idx >= 0 && out_valid && int'(out_index) == hold_idx && hold_cnt < 5) begin
      out_ready = 1'b0;
      hold_cnt++;
    end else begin
      out_ready = 1'b1;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [35:0] exp_q[$];
  logic [31:0] model_mem [N];
  int records = 0;
  int dones = 0;
  int stall_seen = 0;
  bit prev_stall = 1'b0;
  logic [3:0]  prev_idx;
  logic [31:0] prev_data;

  // One dump as seen from outside: each counter's current value (all-ones if its read
  // never answers), in index order; a clearing dump zeroes every counter it could read.
  function automatic void predict(input bit clr);
    for (int i = 0; i < N; i++) begin
      logic [31:0] v;
      v = (i == silent_idx) ? 32'hFFFF_FFFF : model_mem[i];
      exp_q.push_back({4'(i), v});
      if (clr && i != silent_idx) model_mem[i] = 32'h0;
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("read_write_exclusive", {63'h0, mem_read && mem_write}, 64'h0);
      chk("wdata_zero", {32'h0, mem_wdata}, 64'h0);
      if (out_valid) chk("no_read_during_emit", {63'h0, mem_read}, 64'h0);
      if (prev_stall) begin
        chk("stall_valid_held", {63'h0, out_valid}, 64'h1);
        chk("stall_index_held", {60'h0, out_index}, {60'h0, prev_idx});
        chk("stall_data_held", {32'h0, out_data}, {32'h0, prev_data});
      end
      if (out_valid && !out_ready && hold_idx >= 0 && int'(out_index) == hold_idx) stall_seen++;
      if (out_valid && out_ready) begin
        records++;
        if (exp_q.size() == 0) begin
          chk("unexpected_record", {28'h0, out_index, out_data}, 64'h0);
        end else begin
          logic [35:0] e;
          e = exp_q.pop_front();
          chk("record", {28'h0, out_index, out_data}, {28'h0, e});
        end
      end
      if (done) dones++;
      prev_stall = out_valid && !out_ready;
      prev_idx   = out_index;
      prev_data  = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_mem(input int kind);
    if (kind == 0) return;
    for (int i = 0; i < N; i++) begin
      load_vals[i] = (kind == 1) ? 32'(i + 1) : $urandom;
      model_mem[i] = load_vals[i];
    end
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    start = 1'b0;
    clear_after_read = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_dump(input bit clr, input bit spur, input int exp_cycles, input bit exp_err,
                          input int exp_writes, input int exp_stall);
    int w0, d0, r0, n;
    bit seen;
    predict(clr);
    w0 = writes; d0 = dones; r0 = records; stall_seen = 0; hold_cnt = 0;
    @(posedge clk);
    #1 start = 1'b1; clear_after_read = clr;
    @(posedge clk);
    #1 start = 1'b0; clear_after_read = 1'b0;
    chk("busy_after_start", {63'h0, busy}, 64'h1);
    chk("err_cleared_on_start", {63'h0, err}, 64'h0);
    n = 1;
    seen = 1'b0;
    while (n < BUDGET) begin
      if (spur && n == 10) begin start = 1'b1; clear_after_read = ~clr; end
      if (spur && n == 11) begin start = 1'b0; clear_after_read = 1'b0; end
      if (done) begin seen = 1'b1; break; end
      @(posedge clk);
      #1 n++;
    end
    chk("done_seen", {63'h0, seen}, 64'h1);
    if (exp_cycles > 0) chk("done_cycle", 64'(n), 64'(exp_cycles));
    chk("err_at_done", {63'h0, err}, {63'h0, exp_err});
    @(posedge clk);
    #1;
    chk("busy_after_done", {63'h0, busy}, 64'h0);
    chk("done_one_cycle", {63'h0, done}, 64'h0);
    chk("err_sticky", {63'h0, err}, {63'h0, exp_err});
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 64'(dones - d0), 64'd1);
    chk("record_count", 64'(records - r0), 64'(N));
    chk("records_left", 64'(exp_q.size()), 64'd0);
    chk("write_count", 64'(writes - w0), 64'(exp_writes));
    chk("stall_cycles", 64'(stall_seen), 64'(exp_stall));
    if (!seen) begin
      exp_q.delete();
      apply_reset();
    end
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    int load;        // 0 keep, 1 values 1..N, 2 random
    bit clr;
    int silent;
    int lat;
    bit rnd;
    int hold;
    bit spur;
    int exp_cycles;  // 0 = not fixed (random latency/backpressure)
    bit exp_err;
    int exp_writes;
    int exp_stall;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] saved [N];
    int n, w0, r0;

    vecs[0] = '{1, 1'b0, -1, 0, 1'b0, -1, 1'b0, 25,  1'b0, 0,  0};
    vecs[1] = '{1, 1'b1, -1, 0, 1'b0, -1, 1'b0, 37,  1'b0, 12, 0};
    vecs[2] = '{0, 1'b0, -1, 0, 1'b0, -1, 1'b0, 25,  1'b0, 0,  0};
    vecs[3] = '{2, 1'b0, -1, 0, 1'b0, 3,  1'b0, 30,  1'b0, 0,  5};
    vecs[4] = '{2, 1'b0, 7,  0, 1'b0, -1, 1'b0, 88,  1'b1, 0,  0};
    vecs[5] = '{2, 1'b1, 7,  0, 1'b0, -1, 1'b0, 99,  1'b1, 11, 0};
    vecs[6] = '{0, 1'b0, -1, 0, 1'b0, -1, 1'b1, 25,  1'b0, 0,  0};
    vecs[7] = '{2, 1'b0, -1, 3, 1'b1, -1, 1'b0, 0,   1'b0, 0,  0};
    vecs[8] = '{2, 1'b1, -1, 2, 1'b1, -1, 1'b1, 0,   1'b0, 12, 0};
    vecs[9] = '{0, 1'b0, -1, 1, 1'b1, -1, 1'b0, 0,   1'b0, 0,  0};

    rst = 1'b1;
    start = 1'b0;
    clear_after_read = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      load_vals[i] = 32'h0;
      model_mem[i] = 32'h0;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_outputs",
        {15'h0, busy, done, err, mem_read, mem_write, out_valid, out_index, mem_addr[7:0], out_data},
        64'h0);
    chk("reset_addr", {32'h0, mem_addr}, 64'h0);
    rst = 1'b0;
    load_mem(2);

    for (int v = 0; v < 10; v++) begin
      silent_idx = vecs[v].silent;
      lat_max    = vecs[v].lat;
      rnd_ready  = vecs[v].rnd;
      hold_idx   = vecs[v].hold;
      load_mem(vecs[v].load);
      run_dump(vecs[v].clr, vecs[v].spur, vecs[v].exp_cycles, vecs[v].exp_err,
               vecs[v].exp_writes, vecs[v].exp_stall);
    end

    // Reset while clearing counter 5: request drops at once, later counters stay untouched.
    silent_idx = -1; lat_max = 0; rnd_ready = 1'b0; hold_idx = -1;
    load_mem(2);
    for (int i = 0; i < N; i++) saved[i] = model_mem[i];
    predict(1'b1);
    w0 = writes; r0 = records;
    @(posedge clk);
    #1 start = 1'b1; clear_after_read = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; clear_after_read = 1'b0;
    n = 0;
    while (n < 200 && !(mem_write && mem_addr == 32'd5)) begin
      @(posedge clk);
      #1 n++;
    end
    chk("reached_clr_idx5", {63'h0, mem_write && mem_addr == 32'd5}, 64'h1);
    rst = 1'b1;
    #1;
    chk("rst_drops_write", {63'h0, mem_write}, 64'h0);
    chk("rst_drops_busy", {63'h0, busy}, 64'h0);
    chk("rst_drops_valid", {63'h0, out_valid}, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("records_before_rst", 64'(records - r0), 64'd5);
    chk("writes_before_rst", 64'(writes - w0), 64'd5);
    chk("pending_after_rst", 64'(exp_q.size()), 64'd7);
    exp_q.delete();
    for (int i = 5; i < N; i++) model_mem[i] = saved[i];
    run_dump(1'b0, 1'b0, 25, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
